// File: rtl/f32p16_pkg.sv
// Shared constants and types for the float32 -> posit16 conversion slice.
//   FN/N/ES        : float width, posit width, posit exponent size
//   NAR/MAXPOS/MINPOS : special posit16 encodings
//   float_t/posit_t   : convenience vector types
package f32p16_pkg;

  localparam int FN = 32;
  localparam int N  = 16;
  localparam int ES = 1;

  localparam logic [N-1:0] NAR    = 16'h8000;
  localparam logic [N-1:0] MAXPOS = 16'h7FFF;
  localparam logic [N-1:0] MINPOS = 16'h0001;

  typedef logic [FN-1:0] float_t;
  typedef logic [N-1:0]  posit_t;

endpackage

// File: rtl/f32_to_p16.sv
// Combinational float32 -> posit16 (es=1) converter.
//   float_i : IEEE-754 binary32 input
//   posit_o : posit16 result, round-to-nearest-even on the bit string,
//             zero -> 0x0000, Inf/NaN -> NaR, out-of-range magnitudes
//             (including float subnormals) saturate to maxpos/minpos.
// The datapath is written for the 32/16/1 configuration; the parameters
// exist so the instantiating block can pass its own values through.
module f32_to_p16
  import f32p16_pkg::*;
#(
  parameter int N  = 16,
  parameter int ES = 1,
  parameter int FN = 32
) (
  input  logic [FN-1:0] float_i,
  output logic [N-1:0]  posit_o
);

  logic               sign_s;
  logic [7:0]         exp_s;
  logic [22:0]        frac_s;
  logic signed [9:0]  scale_s;
  logic signed [9:0]  k_s;
  logic [5:0]         shamt_s;
  logic [63:0]        body_s;
  logic [63:0]        stream_s;
  logic               round_up_s;
  logic [15:0]        rounded_s;
  logic [15:0]        mag_s;
  logic [15:0]        posit_s;

  assign sign_s = float_i[FN-1];
  assign exp_s  = float_i[FN-2 -: 8];
  assign frac_s = float_i[22:0];

  // Build the regime/exponent/fraction bit stream, round it, then apply specials.
  always_comb begin
    scale_s = $signed({2'b00, exp_s}) - 10'sd127;
    k_s     = scale_s >>> ES;
    // Regime terminator (1 for negative regimes, 0 otherwise), exponent bit,
    // fraction, left-aligned so the regime run can be shifted in from the top.
    body_s  = {k_s[9], scale_s[0], frac_s, 39'd0};
    if (k_s[9]) begin
      shamt_s  = 6'(-k_s);
      stream_s = body_s >> shamt_s;
    end else begin
      shamt_s  = 6'(k_s + 10'sd1);
      stream_s = ~(~64'd0 >> shamt_s) | (body_s >> shamt_s);
    end
    // Top 15 bits are the magnitude; bit 48 is guard, the rest is sticky.
    round_up_s = stream_s[48] & (stream_s[49] | (|stream_s[47:0]));
    rounded_s  = {1'b0, stream_s[63:49]} + {15'd0, round_up_s};
    if (scale_s > 10'sd27) begin
      mag_s = MAXPOS;
    end else if (scale_s < -10'sd28) begin
      mag_s = MINPOS;
    end else begin
      mag_s = rounded_s;
    end
    if (exp_s == 8'hFF) begin
      posit_s = NAR;
    end else if ((exp_s == 8'd0) && (frac_s == 23'd0)) begin
      posit_s = 16'h0000;
    end else if (sign_s) begin
      posit_s = 16'd0 - mag_s;
    end else begin
      posit_s = mag_s;
    end
  end

  assign posit_o = posit_s;

endmodule

// File: rtl/f32p16_conv_arbiter.sv
// Round-robin arbiter + two-stage pipeline sharing one f32_to_p16 converter.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid_i/ready_o   : per-requester handshake (ready is one-hot or zero)
//   req_data_i            : packed floats, requester i at [i*FN +: FN]
//   out_valid_o/ready_i   : result stream handshake
//   out_posit_o/out_id_o  : converted posit and its requester index
//   busy_o                : either stage holds data
//   conv_cnt_o            : completed output handshakes (wrapping)
module f32p16_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int FN   = 32,
  parameter int N    = 16,
  parameter int ES   = 1,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*FN-1:0] req_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [N-1:0]       out_posit_o,
  output logic [IDW-1:0]     out_id_o,
  output logic               busy_o,
  output logic [31:0]        conv_cnt_o
);

  import f32p16_pkg::*;

  logic            s1_valid_q, s1_valid_d;
  logic [FN-1:0]   s1_float_q, s1_float_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    out_posit_q, out_posit_d;
  logic [IDW-1:0]  out_id_q, out_id_d;
  logic [31:0]     conv_cnt_q, conv_cnt_d;

  logic            s2_load_s;
  logic            s1_load_ok_s;
  logic            out_fire_s;
  logic            gnt_any_s;
  logic [IDW-1:0]  gnt_s;
  logic            accept_s;
  logic [N-1:0]    conv_posit_s;

  assign s2_load_s    = s1_valid_q & (~out_valid_q | out_ready_i);
  assign s1_load_ok_s = ~s1_valid_q | s2_load_s;
  assign out_fire_s   = out_valid_q & out_ready_i;
  assign accept_s     = gnt_any_s & s1_load_ok_s & ~rst;

  f32_to_p16 #(
    .N  (N),
    .ES (ES),
    .FN (FN)
  ) u_conv (
    .float_i (s1_float_q),
    .posit_o (conv_posit_s)
  );

  // Round-robin pick: first valid requester at or after rr, wrapping.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_s     = '0;
    for (int j = 0; j < NREQ; j++) begin
      int idx;
      idx = int'(rr_q) + j;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!gnt_any_s && req_valid_i[IDW'(idx)]) begin
        gnt_any_s = 1'b1;
        gnt_s     = IDW'(idx);
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // Only the granted requester sees ready, and only when S1 can take a word.
  always_comb begin
    req_ready_o = '0;
    if (accept_s) begin
      req_ready_o[gnt_s] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Next-state for both stages, the rr pointer and the handshake counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_float_d  = s1_float_q;
    s1_id_d     = s1_id_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_posit_d = out_posit_q;
    out_id_d    = out_id_q;
    conv_cnt_d  = conv_cnt_q;

    // A new accept wins over S1 draining, so a simultaneous advance+accept has no bubble.
    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_float_d = req_data_i[gnt_s*FN +: FN];
      s1_id_d    = gnt_s;
      rr_d       = (gnt_s == IDW'(NREQ - 1)) ? '0 : gnt_s + IDW'(1);
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_load_s) begin
      out_valid_d = 1'b1;
      out_posit_d = conv_posit_s;
      out_id_d    = s1_id_q;
    end else if (out_fire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (out_fire_s) begin
      conv_cnt_d = conv_cnt_q + 32'd1;
    end else begin
      conv_cnt_d = conv_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_float_q  <= '0;
      s1_id_q     <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
      out_id_q    <= '0;
      conv_cnt_q  <= 32'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_float_q  <= s1_float_d;
      s1_id_q     <= s1_id_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_posit_q <= out_posit_d;
      out_id_q    <= out_id_d;
      conv_cnt_q  <= conv_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_posit_o = out_posit_q;
  assign out_id_o    = out_id_q;
  assign busy_o      = s1_valid_q | out_valid_q;
  assign conv_cnt_o  = conv_cnt_q;

endmodule

// File: tb/tb_f32p16_conv_arbiter.sv
module tb_f32p16_conv_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid_i = '0;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ*32-1:0] req_data_i = '0;
  logic              out_valid_o;
  logic              out_ready = 1'b1;
  logic [15:0]       out_posit_o;
  logic [IDW-1:0]    out_id_o;
  logic              busy_o;
  logic [31:0]       conv_cnt_o;

  f32p16_conv_arbiter #(.NREQ(NREQ), .FN(32), .N(16), .ES(1), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .out_posit_o (out_posit_o),
    .out_id_o    (out_id_o),
    .busy_o      (busy_o),
    .conv_cnt_o  (conv_cnt_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference conversion (value domain) ----------------
  real ptab[32768];

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real posit_val(input int p);
    logic [14:0] b;
    int  m, i, k, ex;
    real fr, w;
    b = 15'(p);
    m = 0;
    i = 14;
    while (i >= 0 && b[i] == b[14]) begin m++; i--; end
    k = b[14] ? m - 1 : -m;
    i--;
    ex = 0;
    if (i >= 0) begin ex = int'(b[i]); i--; end
    fr = 1.0;
    w  = 0.5;
    while (i >= 0) begin if (b[i]) fr = fr + w; w = w / 2.0; i--; end
    return pow2(2 * k + ex) * fr;
  endfunction

  function automatic logic [15:0] ref_p16(input logic [31:0] f);
    int  e, bestp;
    real v, d, bd;
    logic [15:0] mag;
    e = int'(f[30:23]);
    if (e == 255) return 16'h8000;
    if (e == 0 && f[22:0] == 23'd0) return 16'h0000;
    if (e == 0) v = real'(f[22:0]) * pow2(-149);
    else        v = (1.0 + real'(f[22:0]) / pow2(23)) * pow2(e - 127);
    if (v >= pow2(28)) mag = 16'h7FFF;
    else if (v <= pow2(-28)) mag = 16'h0001;
    else begin
      bestp = 1;
      bd = 1.0e300;
      for (int p = 1; p < 32768; p++) begin
        d = (ptab[p] > v) ? ptab[p] - v : v - ptab[p];
        if (d < bd || (d == bd && (p % 2) == 0)) begin bd = d; bestp = p; end
      end
      mag = 16'(bestp);
    end
    return f[31] ? 16'h0000 - mag : mag;
  endfunction

  // ---------------- transaction-level model ----------------
  typedef struct { logic [15:0] p; int id; } item_t;
  item_t       mq[$];        // in-flight items, oldest first
  bit          m_head = 1'b0; // oldest item is presented at the output
  int          m_rr   = 0;
  logic [31:0] m_cnt  = 32'd0;
  logic [31:0] rq[NREQ][$];  // per-requester pending floats
  item_t       got_q[$];     // DUT output handshakes
  int          acc_log[$];   // DUT accepts

  function automatic int grant_of(input logic [NREQ-1:0] v, input int rr);
    for (int j = 0; j < NREQ; j++) begin
      if (v[(rr + j) % NREQ]) return (rr + j) % NREQ;
    end
    return -1;
  endfunction

  // Requester index accepted this cycle, or -1.
  function automatic int exp_accept();
    int g;
    bit waiting;
    g = grant_of(req_valid_i, m_rr);
    waiting = (mq.size() - (m_head ? 1 : 0)) > 0;
    if (rst || g < 0) return -1;
    if (waiting && m_head && !out_ready) return -1;
    return g;
  endfunction

  task automatic model_edge();
    int g;
    bit waiting, drain, adv;
    item_t it;
    if (rst) begin
      mq.delete();
      m_head = 1'b0;
      m_rr   = 0;
      m_cnt  = 32'd0;
    end else begin
      g       = exp_accept();
      waiting = (mq.size() - (m_head ? 1 : 0)) > 0;
      drain   = m_head && out_ready;
      adv     = waiting && (!m_head || out_ready);
      if (drain) begin void'(mq.pop_front()); m_cnt = m_cnt + 32'd1; end
      m_head = adv || (m_head && !drain);
      if (g >= 0) begin
        it.p  = ref_p16(rq[g][0]);
        it.id = g;
        mq.push_back(it);
        void'(rq[g].pop_front());
        m_rr = (g + 1) % NREQ;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid_i[i] = rq[i].size() > 0;
      req_data_i[i*32 +: 32] = (rq[i].size() > 0) ? rq[i][0] : 32'd0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    drive();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 1'b0;
    return mq.size() == 0;
  endfunction

  task automatic run_until_idle();
    int n;
    n = 0;
    while (!all_idle() && n < 200) begin tick(); n++; end
    if (!all_idle()) check("drain_timeout", 64'd1, 64'd0);
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] er;
    if (chk_en) begin
      g  = exp_accept();
      er = (g >= 0) ? NREQ'(1) << g : '0;
      check("req_ready", req_ready_o, er);
      check("out_valid", out_valid_o, m_head);
      if (m_head) begin
        check("out_posit", out_posit_o, mq[0].p);
        check("out_id", out_id_o, mq[0].id);
      end
      check("busy", busy_o, mq.size() > 0);
      check("conv_cnt", conv_cnt_o, m_cnt);
      if (out_valid_o && out_ready) begin
        item_t it;
        it.p  = out_posit_o;
        it.id = int'(out_id_o);
        got_q.push_back(it);
      end
      for (int i = 0; i < NREQ; i++) if (req_valid_i[i] && req_ready_o[i]) acc_log.push_back(i);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [31:0] vals[8];

  initial begin
    vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h3F000000, 32'h3FC00000, 32'hBF800000, 32'h41000000};
    for (int p = 1; p < 32768; p++) ptab[p] = posit_val(p);

    // Pin the reference itself.
    check("ref_1p0", ref_p16(32'h3F800000), 16'h4000);
    check("ref_m1p0", ref_p16(32'hBF800000), 16'hC000);
    check("ref_1p5", ref_p16(32'h3FC00000), 16'h4800);

    // Reset.
    rst = 1'b1; out_ready = 1'b1; drive();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cnt", conv_cnt_o, 32'd0);
    check("rst_posit", out_posit_o, 16'h0000);
    check("rst_ready", req_ready_o, 4'b0000);

    // Single requester, basic conversions.
    rq[0].push_back(32'h3F800000); rq[0].push_back(32'h40000000); rq[0].push_back(32'hBF800000);
    drive(); got_q.delete();
    run_until_idle();
    check("single_n", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("single_p0", got_q[0].p, 16'h4000);
      check("single_p1", got_q[1].p, 16'h5000);
      check("single_p2", got_q[2].p, 16'hC000);
      check("single_id", got_q[0].id + got_q[1].id + got_q[2].id, 0);
    end
    check("single_cnt", conv_cnt_o, 32'd3);

    // Specials.
    rq[0].push_back(32'h00000000); rq[0].push_back(32'h7F800000);
    rq[0].push_back(32'h7F000000); rq[0].push_back(32'h00800000);
    drive(); got_q.delete();
    run_until_idle();
    check("spec_n", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("spec_zero", got_q[0].p, 16'h0000);
      check("spec_nar", got_q[1].p, 16'h8000);
      check("spec_max", got_q[2].p, 16'h7FFF);
      check("spec_min", got_q[3].p, 16'h0001);
    end

    // Fairness from rr=0.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) for (int k = 0; k < 2; k++) rq[i].push_back(vals[(i * 2 + k) % 8]);
    drive(); got_q.delete(); acc_log.delete();
    run_until_idle();
    check("fair_acc_n", acc_log.size(), 8);
    check("fair_out_n", got_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (acc_log.size() > k) check("fair_grant", acc_log[k], k % 4);
      if (got_q.size() > k) check("fair_out_id", got_q[k].id, k % 4);
    end

    // Backpressure.
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) for (int k = 0; k < 3; k++) rq[i].push_back(vals[(i + 3 * k) % 8]);
    drive(); got_q.delete(); acc_log.delete();
    repeat (5) tick();
    #1;
    check("bp_accepts", acc_log.size(), 2);
    check("bp_ready", req_ready_o, 4'b0000);
    check("bp_hold_id", out_id_o, 2'd0);
    check("bp_hold_posit", out_posit_o, 16'h4000);
    out_ready = 1'b1;
    run_until_idle();
    check("bp_out_n", got_q.size(), 12);
    for (int k = 0; k < 12; k++) begin
      if (got_q.size() > k && acc_log.size() > k) check("bp_order", got_q[k].id, acc_log[k]);
    end

    // Reset with both stages full.
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) for (int k = 0; k < 3; k++) rq[i].push_back(vals[(i + k) % 8]);
    drive();
    repeat (3) tick();
    #1;
    check("mid_full_busy", busy_o, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    check("mid_out_valid", out_valid_o, 1'b0);
    check("mid_busy", busy_o, 1'b0);
    check("mid_cnt", conv_cnt_o, 32'd0);
    acc_log.delete();
    tick();
    check("mid_first_grant_n", acc_log.size(), 1);
    if (acc_log.size() > 0) check("mid_first_grant", acc_log[0], 0);
    out_ready = 1'b1;
    run_until_idle();

    // Sparse traffic with rr=3.
    rst = 1'b1; tick(); rst = 1'b0;
    rq[2].push_back(32'h40400000); drive();
    run_until_idle();
    rq[2].push_back(32'h3F000000); drive(); got_q.delete(); acc_log.delete();
    #1;
    check("sparse_ready", req_ready_o, 4'b0100);
    run_until_idle();
    check("sparse_n", got_q.size(), 1);
    if (got_q.size() > 0) check("sparse_id", got_q[0].id, 2);
    rq[0].push_back(32'h3F800000); rq[1].push_back(32'h40000000); rq[3].push_back(32'h40800000);
    drive(); acc_log.delete();
    run_until_idle();
    check("sparse_rr_n", acc_log.size(), 3);
    if (acc_log.size() > 0) check("sparse_rr_next", acc_log[0], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
